// File: rtl/song_player.sv
`timescale 1ns/1ps
// song_player: steps through one song held in the external song ROM, times each
// note in duration ticks and drives a square-wave buzzer at the note pitch.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; song index latched on accept
// FETCH | ROM address stable for one cycle; note fields captured
// PLAY  | note sounding; prescaler, tick counter and tone counter run
// GAP   | silent separation between notes (GAP_TICKS ticks)
// DONE  | one-cycle completion pulse, note counter rewinds to 0
module song_player #(
  parameter int SONG_BITS   = 3,
  parameter int CNT_BITS    = 8,
  parameter int TICK_CYCLES = 6250000,
  parameter int GAP_TICKS   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_pause,
  input  logic                 i_stop,
  input  logic [SONG_BITS-1:0] i_song_sel,
  output logic [SONG_BITS-1:0] o_song,
  output logic [CNT_BITS-1:0]  o_cnt,
  input  logic [CNT_BITS-1:0]  i_track,
  input  logic [2:0]           i_octave,
  input  logic [2:0]           i_note,
  input  logic [3:0]           i_length,
  input  logic [2:0]           i_full_note,
  output logic                 o_buzzer,
  output logic                 o_playing,
  output logic                 o_done
);

  localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [11:0] GAP_LAST = 12'(GAP_TICKS);
  localparam logic [CNT_BITS:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PLAY  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  logic [SONG_BITS-1:0] r_song;
  logic [CNT_BITS-1:0]  r_cnt;
  logic                 r_note_on;
  logic [21:0]          r_half_last;
  logic [11:0]          r_dur;
  logic [PRESC_W-1:0]   r_presc;
  logic [11:0]          r_ticks;
  logic [21:0]          r_tone;
  logic                 r_buzzer;
  logic                 r_playing;
  logic                 r_done;

  logic [4:0]  w_len_p1;
  logic [11:0] w_dur;
  logic [21:0] w_base;
  logic [21:0] w_half;
  logic        w_tick;
  logic [11:0] w_ticks_nxt;
  logic        w_last_note;
  logic        w_active;

  // Note duration in ticks: (length+1) << full_note, at most 2048.
  always_comb begin
    w_len_p1 = {1'b0, i_length} + 5'd1;
    w_dur    = {7'd0, w_len_p1} << i_full_note;
  end

  // Half period of the tone in clock cycles, scaled from the middle-octave table.
  always_comb begin
    case (i_note)
      3'd1:    w_base = 22'd191113;
      3'd2:    w_base = 22'd170262;
      3'd3:    w_base = 22'd151686;
      3'd4:    w_base = 22'd143173;
      3'd5:    w_base = 22'd127551;
      3'd6:    w_base = 22'd113636;
      3'd7:    w_base = 22'd101238;
      default: w_base = 22'd0;
    endcase
    if (i_octave >= 3'd4) begin
      w_half = w_base >> (i_octave - 3'd4);
    end else begin
      w_half = w_base << (3'd4 - i_octave);
    end
  end

  // Tick strobe, tick increment and last-note test shared by PLAY and GAP.
  always_comb begin
    w_tick      = (r_presc == PRESC_LAST);
    w_ticks_nxt = r_ticks + 12'd1;
    // Using >= keeps cnt inside the song even if track shrinks mid-song.
    w_last_note = (({1'b0, r_cnt} + CNT_ONE) >= {1'b0, i_track});
    w_active    = (r_state == S_FETCH) || (r_state == S_PLAY) || (r_state == S_GAP);
  end

  // Sequencer: stop beats pause beats start; pause only freezes active states.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_song      <= '0;
      r_cnt       <= '0;
      r_note_on   <= 1'b0;
      r_half_last <= '0;
      r_dur       <= '0;
      r_presc     <= '0;
      r_ticks     <= '0;
      r_tone      <= '0;
      r_buzzer    <= 1'b0;
      r_playing   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_stop) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_presc   <= '0;
        r_ticks   <= '0;
        r_tone    <= '0;
        r_buzzer  <= 1'b0;
        r_playing <= 1'b0;
      end else if (i_pause && w_active) begin
        // Everything holds; the tone resumes from its frozen count, starting low.
        r_buzzer <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_song    <= i_song_sel;
              r_cnt     <= '0;
              r_playing <= 1'b1;
              r_state   <= S_FETCH;
            end
          end

          S_FETCH: begin
            r_presc  <= '0;
            r_ticks  <= '0;
            r_tone   <= '0;
            r_buzzer <= 1'b0;
            if (i_track == '0) begin
              r_playing <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_note_on   <= (i_note != 3'd0);
              r_half_last <= w_half - 22'd1;
              r_dur       <= w_dur;
              r_state     <= S_PLAY;
            end
          end

          S_PLAY: begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick && (w_ticks_nxt == r_dur)) begin
              r_buzzer <= 1'b0;
              r_ticks  <= '0;
              r_tone   <= '0;
              if (GAP_TICKS > 0) begin
                r_state <= S_GAP;
              end else if (w_last_note) begin
                r_playing <= 1'b0;
                r_done    <= 1'b1;
                r_state   <= S_DONE;
              end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_state <= S_FETCH;
              end
            end else begin
              if (w_tick) begin
                r_ticks <= w_ticks_nxt;
              end
              if (r_note_on) begin
                if (r_tone == r_half_last) begin
                  r_tone   <= '0;
                  r_buzzer <= ~r_buzzer;
                end else begin
                  r_tone <= r_tone + 22'd1;
                end
              end
            end
          end

          S_GAP: begin
            r_buzzer <= 1'b0;
            r_presc  <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
              if (w_ticks_nxt == GAP_LAST) begin
                r_ticks <= '0;
                if (w_last_note) begin
                  r_playing <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
                end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= S_FETCH;
                end
              end else begin
                r_ticks <= w_ticks_nxt;
              end
            end
          end

          S_DONE: begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_song    = r_song;
  assign o_cnt     = r_cnt;
  assign o_buzzer  = r_buzzer;
  assign o_playing = r_playing;
  assign o_done    = r_done;

endmodule

// File: tb/tb_song_player.sv
`timescale 1ns/1ps
// tb_song_player: behavioural song ROM, event scoreboard for done pulses and
// buzzer edges, plus per-scenario inline checks of cnt/playing/song.
module tb_song_player;
  localparam int TC = 10;
  localparam int GT = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] song_sel = 3'd0;
  logic [2:0] song;
  logic [7:0] cnt;
  logic [7:0] track;
  logic [2:0] octave;
  logic [2:0] note;
  logic [3:0] length;
  logic [2:0] full_note;
  logic       buzzer;
  logic       playing;
  logic       done;

  song_player #(.SONG_BITS(3), .CNT_BITS(8), .TICK_CYCLES(TC), .GAP_TICKS(GT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_song_sel(song_sel), .o_song(song), .o_cnt(cnt), .i_track(track),
    .i_octave(octave), .i_note(note), .i_length(length), .i_full_note(full_note),
    .o_buzzer(buzzer), .o_playing(playing), .o_done(done)
  );

  always #5 clk = ~clk;

  // Behavioural song ROM
  logic [7:0] rom_track [8];
  logic [2:0] rom_oct   [8][8];
  logic [2:0] rom_note  [8][8];
  logic [3:0] rom_len   [8][8];
  logic [2:0] rom_fn    [8][8];

  assign track     = rom_track[song];
  assign octave    = rom_oct[song][cnt[2:0]];
  assign note      = rom_note[song][cnt[2:0]];
  assign length    = rom_len[song][cnt[2:0]];
  assign full_note = rom_fn[song][cnt[2:0]];

  typedef struct {
    int   kind;   // 0 = done pulse, 1 = buzzer edge
    int   cyc;
    logic val;
  } ev_t;

  ev_t  sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  logic last_buz = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse and buzzer edge must match the next expected event.
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (done === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL done_event: unexpected done pulse at cycle %0d", cyc);
      end else begin
        e = sb_q.pop_front();
        if (e.kind != 0 || e.cyc != cyc) begin
          n_err++;
          $display("FAIL done_event: got done at cycle %0d, expected kind %0d at cycle %0d", cyc, e.kind, e.cyc);
        end
      end
    end
    if (buzzer !== last_buz) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL buzzer_event: unexpected buzzer=%b at cycle %0d", buzzer, cyc);
      end else begin
        e = sb_q.pop_front();
        if (e.kind != 1 || e.cyc != cyc || e.val !== buzzer) begin
          n_err++;
          $display("FAIL buzzer_event: got buzzer=%b at cycle %0d, expected kind %0d val %b at cycle %0d",
                   buzzer, cyc, e.kind, e.val, e.cyc);
        end
      end
    end
    last_buz = buzzer;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic set_note(input int s, input int i, input int oct, input int nt,
                          input int len, input int fn);
    rom_oct[s][i]  = 3'(oct);
    rom_note[s][i] = 3'(nt);
    rom_len[s][i]  = 4'(len);
    rom_fn[s][i]   = 3'(fn);
  endtask

  function automatic int half_of(input int oct, input int nt);
    int base;
    case (nt)
      1: base = 191113;
      2: base = 170262;
      3: base = 151686;
      4: base = 143173;
      5: base = 127551;
      6: base = 113636;
      7: base = 101238;
      default: base = 0;
    endcase
    if (oct >= 4) return base >> (oct - 4);
    return base << (4 - oct);
  endfunction

  // Expected event schedule for an uninterrupted song whose start is driven at cycle s0.
  task automatic model_song(input int s, input int s0, output int done_c);
    int t, p, d, h, k;
    logic v;
    t = s0 + 1;
    for (int i = 0; i < int'(rom_track[s]); i++) begin
      p = t + 1;
      d = ((int'(rom_len[s][i]) + 1) << rom_fn[s][i]) * TC;
      if (rom_note[s][i] != 3'd0) begin
        h = half_of(int'(rom_oct[s][i]), int'(rom_note[s][i]));
        v = 1'b0;
        k = 1;
        while (k * h < d) begin
          v = ~v;
          sb_q.push_back(ev_t'{1, p + k * h, v});
          k++;
        end
        if (v) sb_q.push_back(ev_t'{1, p + d, 1'b0});
      end
      t = p + d + GT * TC;
    end
    if (rom_track[s] == 8'd0) t = t + 1;
    sb_q.push_back(ev_t'{0, t, 1'b1});
    done_c = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_checks++;
    if ({song, cnt, buzzer, playing, done} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_held: got song=%0d cnt=%0d buz=%b play=%b done=%b, expected all 0",
               song, cnt, buzzer, playing, done);
    end
    rst_n = 1'b1;
    tick(3);
    n_checks++;
    if ({song, cnt, buzzer, playing, done} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_idle: got song=%0d cnt=%0d buz=%b play=%b done=%b, expected all 0",
               song, cnt, buzzer, playing, done);
    end
  endtask

  task automatic test_two_note();
    int s0, dc;
    song_sel = 3'd1; start = 1'b1; s0 = cyc;
    model_song(1, s0, dc);
    tick(1);
    start = 1'b0; song_sel = 3'd5;
    n_checks++;
    if (playing !== 1'b1 || song !== 3'd1 || cnt !== 8'd0) begin
      n_err++;
      $display("FAIL two_note_fetch: got play=%b song=%0d cnt=%0d, expected 1/1/0", playing, song, cnt);
    end
    wait_to(s0 + 170);
    n_checks++;
    if (cnt !== 8'd0 || playing !== 1'b1) begin
      n_err++;
      $display("FAIL two_note_gap: got cnt=%0d play=%b, expected 0/1", cnt, playing);
    end
    wait_to(s0 + 175);
    n_checks++;
    if (cnt !== 8'd1 || song !== 3'd1) begin
      n_err++;
      $display("FAIL two_note_second: got cnt=%0d song=%0d, expected 1/1", cnt, song);
    end
    wait_to(dc);
    n_checks++;
    if (done !== 1'b1 || cnt !== 8'd1) begin
      n_err++;
      $display("FAIL two_note_done: got done=%b cnt=%0d, expected 1/1", done, cnt);
    end
    wait_to(dc + 1);
    n_checks++;
    if (cnt !== 8'd0 || playing !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL two_note_after: got cnt=%0d play=%b done=%b, expected 0/0/0", cnt, playing, done);
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL two_note_events: %0d expected events never seen, expected 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_track0();
    int s0, dc;
    song_sel = 3'd0; start = 1'b1; s0 = cyc;
    model_song(0, s0, dc);
    tick(1);
    start = 1'b0;
    n_checks++;
    if (playing !== 1'b1) begin
      n_err++;
      $display("FAIL track0_fetch: got play=%b, expected 1", playing);
    end
    wait_to(s0 + 2);
    n_checks++;
    if (done !== 1'b1 || playing !== 1'b0) begin
      n_err++;
      $display("FAIL track0_done: got done=%b play=%b, expected 1/0", done, playing);
    end
    wait_to(s0 + 3);
    n_checks++;
    if (done !== 1'b0 || playing !== 1'b0 || cnt !== 8'd0) begin
      n_err++;
      $display("FAIL track0_idle: got done=%b play=%b cnt=%0d, expected 0/0/0", done, playing, cnt);
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL track0_events: %0d expected events never seen, expected 0", sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_pause();
    int s0;
    song_sel = 3'd1; start = 1'b1; s0 = cyc;
    sb_q.push_back(ev_t'{0, s0 + 543, 1'b1});
    tick(1);
    start = 1'b0;
    wait_to(s0 + 52);
    pause = 1'b1;
    wait_to(s0 + 100);
    n_checks++;
    if (cnt !== 8'd0 || playing !== 1'b1 || buzzer !== 1'b0) begin
      n_err++;
      $display("FAIL pause_frozen: got cnt=%0d play=%b buz=%b, expected 0/1/0", cnt, playing, buzzer);
    end
    wait_to(s0 + 252);
    pause = 1'b0;
    wait_to(s0 + 371);
    n_checks++;
    if (cnt !== 8'd0) begin
      n_err++;
      $display("FAIL pause_note0_end: got cnt=%0d one cycle before note 1, expected 0", cnt);
    end
    tick(1);
    n_checks++;
    if (cnt !== 8'd1) begin
      n_err++;
      $display("FAIL pause_note1_start: got cnt=%0d, expected 1", cnt);
    end
    wait_to(s0 + 544);
    n_checks++;
    if (cnt !== 8'd0 || playing !== 1'b0 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL pause_finish: got cnt=%0d play=%b pending=%0d, expected 0/0/0", cnt, playing, sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_stop();
    int s0;
    song_sel = 3'd1; start = 1'b1; s0 = cyc;
    tick(1);
    start = 1'b0;
    wait_to(s0 + 200);
    n_checks++;
    if (cnt !== 8'd1) begin
      n_err++;
      $display("FAIL stop_pre: got cnt=%0d, expected 1", cnt);
    end
    stop = 1'b1; pause = 1'b1;
    tick(1);
    stop = 1'b0; pause = 1'b0;
    n_checks++;
    if (playing !== 1'b0 || cnt !== 8'd0 || buzzer !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL stop_idle: got play=%b cnt=%0d buz=%b done=%b, expected 0/0/0/0", playing, cnt, buzzer, done);
    end
    tick(400);
    n_checks++;
    if (playing !== 1'b0 || cnt !== 8'd0) begin
      n_err++;
      $display("FAIL stop_stays: got play=%b cnt=%0d, expected 0/0", playing, cnt);
    end
  endtask

  task automatic test_back_to_back();
    int s0, dc1, dc2;
    song_sel = 3'd2; start = 1'b1; s0 = cyc;
    model_song(2, s0, dc1);
    model_song(2, dc1 + 1, dc2);
    wait_to(s0 + 15);
    n_checks++;
    if (cnt !== 8'd0 || playing !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_held_start: got cnt=%0d play=%b, expected 0/1", cnt, playing);
    end
    wait_to(dc1 + 1);
    n_checks++;
    if (playing !== 1'b0 || cnt !== 8'd0) begin
      n_err++;
      $display("FAIL b2b_idle: got play=%b cnt=%0d, expected 0/0", playing, cnt);
    end
    wait_to(dc1 + 2);
    n_checks++;
    if (playing !== 1'b1 || cnt !== 8'd0 || song !== 3'd2) begin
      n_err++;
      $display("FAIL b2b_restart: got play=%b cnt=%0d song=%0d, expected 1/0/2", playing, cnt, song);
    end
    wait_to(dc2);
    start = 1'b0;
    wait_to(dc2 + 2);
    n_checks++;
    if (playing !== 1'b0 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_finish: got play=%b pending=%0d, expected 0/0", playing, sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_async_reset();
    int s0, s1, dc;
    song_sel = 3'd1; start = 1'b1; s0 = cyc;
    tick(1);
    start = 1'b0;
    wait_to(s0 + 180);
    n_checks++;
    if (cnt !== 8'd1 || playing !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre: got cnt=%0d play=%b, expected 1/1", cnt, playing);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({song, cnt, buzzer, playing, done} !== 14'd0) begin
      n_err++;
      $display("FAIL arst_immediate: got song=%0d cnt=%0d buz=%b play=%b done=%b, expected all 0",
               song, cnt, buzzer, playing, done);
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    song_sel = 3'd1; start = 1'b1; s1 = cyc;
    model_song(1, s1, dc);
    tick(1);
    start = 1'b0;
    n_checks++;
    if (cnt !== 8'd0 || song !== 3'd1 || playing !== 1'b1) begin
      n_err++;
      $display("FAIL arst_replay: got cnt=%0d song=%0d play=%b, expected 0/1/1", cnt, song, playing);
    end
    wait_to(dc + 1);
    n_checks++;
    if (playing !== 1'b0 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL arst_finish: got play=%b pending=%0d, expected 0/0", playing, sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_octaves();
    int s0, dc;
    song_sel = 3'd4; start = 1'b1; s0 = cyc;
    model_song(4, s0, dc);
    tick(1);
    start = 1'b0;
    wait_to(dc + 1);
    n_checks++;
    if (cnt !== 8'd0 || playing !== 1'b0 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL octaves_finish: got cnt=%0d play=%b pending=%0d, expected 0/0/0", cnt, playing, sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic test_tone_pause();
    int s0;
    song_sel = 3'd3; start = 1'b1; s0 = cyc;
    // Half period of B at octave 7 is 12654 cycles; 220 paused cycles shift everything.
    sb_q.push_back(ev_t'{1, s0 + 12856, 1'b1});
    sb_q.push_back(ev_t'{1, s0 + 12951, 1'b0});
    sb_q.push_back(ev_t'{0, s0 + 13032, 1'b1});
    tick(1);
    start = 1'b0;
    wait_to(s0 + 100);
    pause = 1'b1;
    wait_to(s0 + 200);
    n_checks++;
    if (buzzer !== 1'b0 || playing !== 1'b1 || cnt !== 8'd0) begin
      n_err++;
      $display("FAIL tone_pause_frozen: got buz=%b play=%b cnt=%0d, expected 0/1/0", buzzer, playing, cnt);
    end
    wait_to(s0 + 300);
    pause = 1'b0;
    wait_to(s0 + 12950);
    n_checks++;
    if (buzzer !== 1'b1) begin
      n_err++;
      $display("FAIL tone_high: got buz=%b, expected 1", buzzer);
    end
    pause = 1'b1;
    wait_to(s0 + 12970);
    pause = 1'b0;
    wait_to(s0 + 13033);
    n_checks++;
    if (playing !== 1'b0 || buzzer !== 1'b0 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL tone_pause_finish: got play=%b buz=%b pending=%0d, expected 0/0/0", playing, buzzer, sb_q.size());
    end
    sb_q.delete();
  endtask

  initial begin
    for (int s = 0; s < 8; s++) begin
      rom_track[s] = 8'd0;
      for (int i = 0; i < 8; i++) set_note(s, i, 4, 0, 0, 0);
    end
    rom_track[1] = 8'd2;
    set_note(1, 0, 4, 1, 0, 4);
    set_note(1, 1, 4, 1, 0, 4);
    rom_track[2] = 8'd2;
    set_note(2, 0, 4, 3, 0, 0);
    set_note(2, 1, 4, 3, 0, 0);
    rom_track[3] = 8'd1;
    set_note(3, 0, 7, 7, 9, 7);
    rom_track[4] = 8'd5;
    set_note(4, 0, 7, 7, 9, 7);
    set_note(4, 1, 3, 1, 0, 4);
    set_note(4, 2, 7, 0, 15, 3);
    set_note(4, 3, 5, 1, 0, 4);
    set_note(4, 4, 7, 5, 12, 7);

    test_reset();
    test_two_note();      tick(3);
    test_track0();        tick(3);
    test_pause();         tick(3);
    test_stop();          tick(3);
    test_back_to_back();  tick(3);
    test_async_reset();   tick(3);
    test_octaves();       tick(3);
    test_tone_pause();    tick(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d, errors=%0d", cyc, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
